universal_register: RTL and testbench



---
 rtl/universal_register_pkg.sv | 15 +
 rtl/ur_next_value.sv | 65 ++++++
 rtl/universal_register.sv | 48 ++++
 tb/tb_universal_register.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/universal_register_pkg.sv
// Shared definitions for the universal datapath register: operation encoding.
package universal_register_pkg;

  localparam int OP_WIDTH = 3;

  localparam logic [OP_WIDTH-1:0] OP_HOLD = 3'b000;
  localparam logic [OP_WIDTH-1:0] OP_LOAD = 3'b001;
  localparam logic [OP_WIDTH-1:0] OP_INC  = 3'b010;
  localparam logic [OP_WIDTH-1:0] OP_DEC  = 3'b011;
  localparam logic [OP_WIDTH-1:0] OP_SHL  = 3'b100;
  localparam logic [OP_WIDTH-1:0] OP_SHR  = 3'b101;
  localparam logic [OP_WIDTH-1:0] OP_ROL  = 3'b110;
  localparam logic [OP_WIDTH-1:0] OP_CLR  = 3'b111;

endpackage

// File: rtl/ur_next_value.sv
// Next-state logic for the universal register: computes the value and the
// carry/borrow/shifted-out bit that the selected operation would produce.
module ur_next_value
  import universal_register_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]    q,
  input  logic                carry,
  input  logic [OP_WIDTH-1:0] op,
  input  logic [WIDTH-1:0]    in,
  input  logic                serial_in,
  output logic [WIDTH-1:0]    q_next,
  output logic                carry_next
);

  // Arithmetic is done one bit wider so the top bit is the carry or borrow.
  logic [WIDTH:0] inc_sum;
  logic [WIDTH:0] dec_diff;

  assign inc_sum  = {1'b0, q} + (WIDTH + 1)'(1);
  assign dec_diff = {1'b0, q} - (WIDTH + 1)'(1);

  // Select the result of the requested operation.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs; a missed
    // branch would otherwise infer a latch. They also make unknown op hold.
    q_next     = q;
    carry_next = carry;
    case (op)
      OP_HOLD: ;
      OP_LOAD: begin
        q_next     = in;
        carry_next = 1'b0;
      end
      OP_INC: begin
        q_next     = inc_sum[WIDTH-1:0];
        carry_next = inc_sum[WIDTH];
      end
      OP_DEC: begin
        q_next     = dec_diff[WIDTH-1:0];
        carry_next = dec_diff[WIDTH];
      end
      OP_SHL: begin
        q_next     = {q[WIDTH-2:0], serial_in};
        carry_next = q[WIDTH-1];
      end
      OP_SHR: begin
        q_next     = {serial_in, q[WIDTH-1:1]};
        carry_next = q[0];
      end
      OP_ROL: begin
        q_next     = {q[WIDTH-2:0], q[WIDTH-1]};
        carry_next = q[WIDTH-1];
      end
      OP_CLR: begin
        // Clears to zero, deliberately not to the reset value.
        q_next     = '0;
        carry_next = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/universal_register.sv
// Universal datapath register (PC, AR, AC, shift registers): one operation
// per clock, registered carry, combinational zero flag.
module universal_register
  import universal_register_pkg::*;
#(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                CLK,
  input  logic                clear,
  input  logic                enable,
  input  logic [OP_WIDTH-1:0] op,
  input  logic [WIDTH-1:0]    in,
  input  logic                serial_in,
  output logic [WIDTH-1:0]    Q,
  output logic                carry,
  output logic                zero
);

  logic [WIDTH-1:0] q_next;
  logic             carry_next;

  ur_next_value #(.WIDTH(WIDTH)) u_next (
    .q          (Q),
    .carry      (carry),
    .op         (op),
    .in         (in),
    .serial_in  (serial_in),
    .q_next     (q_next),
    .carry_next (carry_next)
  );

  // Register state: async reset to RESET_VALUE, update only when enabled.
  always_ff @(posedge CLK or posedge clear) begin
    // NOTE: non-blocking assignments so Q and carry both update from the
    // pre-edge values, like real flops.
    if (clear) begin
      Q     <= RESET_VALUE;
      carry <= 1'b0;
    end else if (enable) begin
      Q     <= q_next;
      carry <= carry_next;
    end
  end

  assign zero = (Q == '0);

endmodule

// File: tb/tb_universal_register.sv
// Directed bench for universal_register: a 4-bit instance with reset value 0
// and an 8-bit instance with reset value 8'h5A.
module tb_universal_register;
  import universal_register_pkg::*;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  // 4-bit instance
  logic                a_clear, a_en, a_si;
  logic [OP_WIDTH-1:0] a_op;
  logic [3:0]          a_in, a_q;
  logic                a_carry, a_zero;

  // 8-bit instance
  logic                b_clear, b_en, b_si;
  logic [OP_WIDTH-1:0] b_op;
  logic [7:0]          b_in, b_q;
  logic                b_carry, b_zero;

  int errors = 0;
  int checks = 0;

  universal_register #(.WIDTH(4)) dut_a (
    .CLK       (CLK),
    .clear     (a_clear),
    .enable    (a_en),
    .op        (a_op),
    .in        (a_in),
    .serial_in (a_si),
    .Q         (a_q),
    .carry     (a_carry),
    .zero      (a_zero)
  );

  universal_register #(.WIDTH(8), .RESET_VALUE(8'h5A)) dut_b (
    .CLK       (CLK),
    .clear     (b_clear),
    .enable    (b_en),
    .op        (b_op),
    .in        (b_in),
    .serial_in (b_si),
    .Q         (b_q),
    .carry     (b_carry),
    .zero      (b_zero)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and sample 1 time unit after it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Check Q, carry and zero of the 4-bit instance together.
  task automatic check_a(input string tag, input logic [3:0] q, input logic c);
    check({tag, ".q"}, {4'h0, a_q}, {4'h0, q});
    check({tag, ".carry"}, {7'h0, a_carry}, {7'h0, c});
    check({tag, ".zero"}, {7'h0, a_zero}, {7'h0, (q == 4'h0)});
  endtask

  task automatic check_b(input string tag, input logic [7:0] q, input logic c);
    check({tag, ".q"}, b_q, q);
    check({tag, ".carry"}, {7'h0, b_carry}, {7'h0, c});
    check({tag, ".zero"}, {7'h0, b_zero}, {7'h0, (q == 8'h00)});
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin : stimulus
    a_clear = 1'b1; a_en = 1'b0; a_op = OP_HOLD; a_in = 4'h0; a_si = 1'b0;
    b_clear = 1'b1; b_en = 1'b0; b_op = OP_HOLD; b_in = 8'h00; b_si = 1'b0;
    tick();
    tick();
    check_a("rst_a", 4'h0, 1'b0);
    check_b("rst_b", 8'h5A, 1'b0);
    a_clear = 1'b0;
    b_clear = 1'b0;

    // ---- Reset behaviour (4-bit) ----
    a_en = 1'b1; a_op = OP_LOAD; a_in = 4'hC;
    tick();
    check_a("load_c", 4'hC, 1'b0);
    #2 a_clear = 1'b1;
    #1 check_a("async_clr", 4'h0, 1'b0);
    tick();
    check_a("clr_edge1", 4'h0, 1'b0);
    tick();
    check_a("clr_edge2", 4'h0, 1'b0);
    a_clear = 1'b0;
    tick();
    check_a("post_release", 4'hC, 1'b0);

    // ---- INC / DEC wrap and flags ----
    a_in = 4'hF;
    tick();
    check_a("load_f", 4'hF, 1'b0);
    a_op = OP_INC;
    tick();
    check_a("inc_wrap", 4'h0, 1'b1);
    tick();
    check_a("inc_1", 4'h1, 1'b0);
    a_op = OP_DEC;
    tick();
    check_a("dec_0", 4'h0, 1'b0);
    tick();
    check_a("dec_wrap", 4'hF, 1'b1);
    // Async clear must also drop a set carry.
    #2 a_clear = 1'b1;
    #1 check_a("clr_carry", 4'h0, 1'b0);
    a_clear = 1'b0;

    // ---- Shifts and rotate ----
    a_op = OP_LOAD; a_in = 4'hA;
    tick();
    check_a("load_a", 4'hA, 1'b0);
    a_op = OP_SHL; a_si = 1'b1;
    tick();
    check_a("shl", 4'h5, 1'b1);
    a_op = OP_SHR; a_si = 1'b0;
    tick();
    check_a("shr", 4'h2, 1'b1);
    a_op = OP_LOAD; a_in = 4'h9;
    tick();
    check_a("load_9", 4'h9, 1'b0);
    a_op = OP_ROL; a_si = 1'b0;
    tick();
    check_a("rol", 4'h3, 1'b1);

    // ---- Enable gating: Q=0011 and carry=1 must both hold ----
    a_en = 1'b0; a_op = OP_LOAD; a_in = 4'hA;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_a("en_off", 4'h3, 1'b1);
    end
    a_en = 1'b1; a_op = OP_HOLD;
    tick();
    check_a("hold", 4'h3, 1'b1);
    a_op = OP_CLR;
    tick();
    check_a("sync_clr", 4'h0, 1'b0);

    // ---- Mid-operation reset while counting ----
    a_op = OP_INC;
    tick();
    check_a("cnt_1", 4'h1, 1'b0);
    tick();
    check_a("cnt_2", 4'h2, 1'b0);
    tick();
    check_a("cnt_3", 4'h3, 1'b0);
    #2 a_clear = 1'b1;
    #1 check_a("mid_clr", 4'h0, 1'b0);
    tick();
    check_a("mid_clr_edge", 4'h0, 1'b0);
    a_clear = 1'b0;
    tick();
    check_a("resume_1", 4'h1, 1'b0);
    tick();
    check_a("resume_2", 4'h2, 1'b0);
    a_en = 1'b0;

    // ---- 8-bit instance with non-zero reset value ----
    b_en = 1'b1; b_op = OP_LOAD; b_in = 8'hFF;
    tick();
    check_b("b_load_ff", 8'hFF, 1'b0);
    b_op = OP_INC;
    tick();
    check_b("b_inc_wrap", 8'h00, 1'b1);
    #2 b_clear = 1'b1;
    #1 check_b("b_async_clr", 8'h5A, 1'b0);
    tick();
    check_b("b_clr_edge", 8'h5A, 1'b0);
    b_clear = 1'b0;
    b_op = OP_SHL; b_si = 1'b1;
    tick();
    check_b("b_shl", 8'hB5, 1'b0);
    b_op = OP_CLR;
    tick();
    check_b("b_sync_clr", 8'h00, 1'b0);
    b_op = OP_DEC;
    tick();
    check_b("b_dec_wrap", 8'hFF, 1'b1);
    b_op = OP_ROL;
    tick();
    check_b("b_rol", 8'hFF, 1'b1);
    b_op = OP_SHR; b_si = 1'b0;
    tick();
    check_b("b_shr", 8'h7F, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
